// File: rtl/r8_ppgen_pipe.sv
// Radix-8 Booth partial-product generator feeding the first reduction stage
// of the mantissa multiplier: stage 1 builds 3A and recodes B, stage 2 encodes.
module r8_ppgen_pipe #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_a,
    input  logic [23:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [26:0]      pp0,
    output logic [26:0]      pp1,
    output logic [26:0]      pp2,
    output logic [26:0]      pp3,
    output logic [26:0]      pp4,
    output logic [26:0]      pp5,
    output logic [26:0]      pp6,
    output logic [25:0]      pp7,
    output logic [22:0]      pp8,
    output logic [TAG_W-1:0] out_tag
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high. The sender holds its payload stable while valid & ~ready;
    // ready may depend combinationally on the downstream ready.

    // One-hot magnitude select: bit k means |d| = k.
    function automatic logic [4:0] booth_sel(input logic [3:0] g);
        logic [4:0] s;
        case (g)
            4'b0000, 4'b1111:                   s = 5'b00001;
            4'b0001, 4'b0010, 4'b1101, 4'b1110: s = 5'b00010;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: s = 5'b00100;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: s = 5'b01000;
            default:                            s = 5'b10000;
        endcase
        return s;
    endfunction

    // Exact two's-complement multiple with the sign bit flipped; a "-0" digit
    // never reaches here with neg set, so zero always encodes as positive.
    function automatic logic [26:0] enc_pp(input logic [4:0] sel, input logic neg,
                                           input logic [23:0] a, input logic [25:0] a3);
        logic [26:0] mag;
        logic [26:0] m;
        case (sel)
            5'b00010: mag = {3'b000, a};
            5'b00100: mag = {2'b00, a, 1'b0};
            5'b01000: mag = {1'b0, a3};
            5'b10000: mag = {1'b0, a, 2'b00};
            default:  mag = '0;
        endcase
        m = neg ? (~mag + 27'd1) : mag;
        return {~m[26], m[25:0]};
    endfunction

    logic                   s1_valid;
    logic [23:0]            s1_a;
    logic [25:0]            s1_a3;
    logic [8:0][4:0]        s1_sel;
    logic [8:0]             s1_neg;
    logic [TAG_W-1:0]       s1_tag;

    logic                   s1_load;
    logic                   s2_load;

    logic [27:0]            bx;
    logic [8:0][4:0]        sel_d;
    logic [8:0]             neg_d;
    logic [25:0]            a3_d;

    logic [6:0][26:0]       enc_lo_d;
    logic [25:0]            enc7_d;
    logic [22:0]            enc8_d;

    logic [6:0][26:0]       pp_lo_q;
    logic [25:0]            pp7_q;
    logic [22:0]            pp8_q;
    logic [TAG_W-1:0]       tag_q;

    assign s2_load  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    // Recode: overlapping 4-bit windows of {000, B, 0}, stride 3.
    always_comb begin
        bx    = {3'b000, in_b, 1'b0};
        sel_d = '0;
        neg_d = '0;
        for (int i = 0; i < 9; i++) begin
            sel_d[i] = booth_sel(bx[3*i +: 4]);
            neg_d[i] = bx[3*i+3] & ~(&bx[3*i +: 3]);
        end
        a3_d = {2'b00, in_a} + {1'b0, in_a, 1'b0};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_a3    <= '0;
            s1_sel   <= '0;
            s1_neg   <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_a3    <= a3_d;
            s1_sel   <= sel_d;
            s1_neg   <= neg_d;
            s1_tag   <= in_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // pp7 and pp8 only carry the columns the reduction tree uses.
    always_comb begin
        enc_lo_d = '0;
        for (int i = 0; i < 7; i++) begin
            enc_lo_d[i] = enc_pp(s1_sel[i], s1_neg[i], s1_a, s1_a3);
        end
        enc7_d = 26'(enc_pp(s1_sel[7], s1_neg[7], s1_a, s1_a3));
        enc8_d = 23'(enc_pp(s1_sel[8], s1_neg[8], s1_a, s1_a3));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            pp_lo_q   <= '0;
            pp7_q     <= '0;
            pp8_q     <= '0;
            tag_q     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                pp_lo_q <= enc_lo_d;
                pp7_q   <= enc7_d;
                pp8_q   <= enc8_d;
                tag_q   <= s1_tag;
            end
        end
    end

    assign pp0     = pp_lo_q[0];
    assign pp1     = pp_lo_q[1];
    assign pp2     = pp_lo_q[2];
    assign pp3     = pp_lo_q[3];
    assign pp4     = pp_lo_q[4];
    assign pp5     = pp_lo_q[5];
    assign pp6     = pp_lo_q[6];
    assign pp7     = pp7_q;
    assign pp8     = pp8_q;
    assign out_tag = tag_q;

endmodule
